// File: rtl/axi_lite_master_if.sv
// axi_lite_master_if: AXI-Lite bus between the initiator and a CSR slave.
interface axi_lite_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_master.sv
// axi_lite_master: turns single register commands into AXI-Lite transactions,
// one outstanding at a time, with a per-transaction timeout.
module axi_lite_master #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = DATA_W / 8,
    parameter int TXN_TIMEOUT = 50
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [STRB_W-1:0]   cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    axi_lite_master_if.master   axi
);
    localparam int TW = $clog2(TXN_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic [ADDR_W-1:0] awaddr_q, awaddr_nxt, araddr_q, araddr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt, rsp_rdata_nxt;
    logic [STRB_W-1:0] wstrb_q, wstrb_nxt;
    logic              awvalid_q, awvalid_nxt, wvalid_q, wvalid_nxt, arvalid_q, arvalid_nxt;
    logic              rsp_valid_nxt, rsp_timeout_nxt;
    logic [1:0]        rsp_resp_nxt;
    logic              aw_hs, w_hs, expire, abort;

    assign cmd_ready   = state == IDLE;
    assign axi.bready  = state == IDLE || state == WR_B;
    assign axi.rready  = state == IDLE || state == RD_R;
    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;

    assign aw_hs  = awvalid_q && axi.awready;
    assign w_hs   = wvalid_q && axi.wready;
    assign expire = timer == TW'(TXN_TIMEOUT - 1);

    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer;
        awaddr_nxt      = awaddr_q;
        wdata_nxt       = wdata_q;
        wstrb_nxt       = wstrb_q;
        araddr_nxt      = araddr_q;
        awvalid_nxt     = awvalid_q;
        wvalid_nxt      = wvalid_q;
        arvalid_nxt     = arvalid_q;
        rsp_valid_nxt   = rsp_valid;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_resp_nxt    = rsp_resp;
        rsp_timeout_nxt = rsp_timeout;
        abort           = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                timer_nxt = '0;
                if (cmd_write) begin
                    awaddr_nxt  = cmd_addr;
                    wdata_nxt   = cmd_wdata;
                    wstrb_nxt   = cmd_wstrb;
                    awvalid_nxt = 1'b1;
                    wvalid_nxt  = 1'b1;
                    state_nxt   = WR_AW_W;
                end else begin
                    araddr_nxt  = cmd_addr;
                    arvalid_nxt = 1'b1;
                    state_nxt   = RD_AR;
                end
            end
            WR_AW_W: begin
                timer_nxt   = timer + 1'b1;
                awvalid_nxt = awvalid_q && !aw_hs;
                wvalid_nxt  = wvalid_q && !w_hs;
                // a channel whose valid is already low completed earlier
                if (!awvalid_nxt && !wvalid_nxt) state_nxt = WR_B;
                else abort = expire;
            end
            WR_B: begin
                timer_nxt = timer + 1'b1;
                if (axi.bvalid) begin
                    rsp_resp_nxt    = axi.bresp;
                    rsp_rdata_nxt   = '0;
                    rsp_timeout_nxt = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    state_nxt       = RSP;
                end else abort = expire;
            end
            RD_AR: begin
                timer_nxt = timer + 1'b1;
                if (arvalid_q && axi.arready) begin
                    arvalid_nxt = 1'b0;
                    state_nxt   = RD_R;
                end else abort = expire;
            end
            RD_R: begin
                timer_nxt = timer + 1'b1;
                if (axi.rvalid) begin
                    rsp_resp_nxt    = axi.rresp;
                    rsp_rdata_nxt   = axi.rdata;
                    rsp_timeout_nxt = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    state_nxt       = RSP;
                end else abort = expire;
            end
            RSP: if (rsp_ready) begin
                rsp_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            awvalid_nxt     = 1'b0;
            wvalid_nxt      = 1'b0;
            arvalid_nxt     = 1'b0;
            rsp_resp_nxt    = 2'b10;
            rsp_rdata_nxt   = '0;
            rsp_timeout_nxt = 1'b1;
            rsp_valid_nxt   = 1'b1;
            state_nxt       = RSP;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            timer       <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            awaddr_q    <= awaddr_nxt;
            wdata_q     <= wdata_nxt;
            wstrb_q     <= wstrb_nxt;
            araddr_q    <= araddr_nxt;
            awvalid_q   <= awvalid_nxt;
            wvalid_q    <= wvalid_nxt;
            arvalid_q   <= arvalid_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_resp    <= rsp_resp_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end
endmodule
